ecc_160_err_monitor: RTL and testbench

- Downstream stage of the 160-bit ECC fault-detect checker on the FIFO read path.
- Registers the checked read data and its error flags for the consumer.
- Keeps saturating sbit/dbit/fault counters and captures the first error's address and type.
- Raises a level interrupt until software clears it with a one-cycle clear pulse.

---
 rtl/ecc_mon_pkg.sv | 23 ++
 rtl/ecc_sat_cnt.sv | 35 +++
 rtl/ecc_160_err_monitor.sv | 122 ++++++++++++
 tb/tb_ecc_160_err_monitor.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/ecc_mon_pkg.sv
// Shared encodings for the ECC error monitor: error-type codes, capture FSM
// states and the priority encoder that maps a beat's flags to a type.
package ecc_mon_pkg;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_SBIT  = 2'b01;
    localparam logic [1:0] ERR_DBIT  = 2'b10;
    localparam logic [1:0] ERR_FAULT = 2'b11;

    localparam logic [0:0] CAP_IDLE = 1'b0;
    localparam logic [0:0] CAP_HELD = 1'b1;

    // Checker self-fault outranks an uncorrectable error, which outranks a corrected one.
    function automatic logic [1:0] err_type(input logic sbit, input logic dbit, input logic fault);
        logic [1:0] t;
        t = ERR_NONE;
        if (fault)     t = ERR_FAULT;
        else if (dbit) t = ERR_DBIT;
        else if (sbit) t = ERR_SBIT;
        return t;
    endfunction

endpackage

// File: rtl/ecc_sat_cnt.sv
// Saturating event counter; clr zeroes the count before the same-cycle
// increment is applied, so a clear plus an event leaves the count at 1.
module ecc_sat_cnt #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] cnt
);

    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;
    logic [CNT_WIDTH-1:0] base;

    always_comb begin
        base  = clr ? '0 : cnt_q;
        cnt_d = base;
        if (inc && (base != {CNT_WIDTH{1'b1}})) begin
            cnt_d = base + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/ecc_160_err_monitor.sv
// Registers checked FIFO read beats and tracks ECC errors: saturating counters,
// first-error capture and a sticky interrupt cleared by a one-cycle clr pulse.
module ecc_160_err_monitor
    import ecc_mon_pkg::*;
#(
    parameter int                   DATA_WIDTH  = 160,
    parameter int                   ADDR_WIDTH  = 8,
    parameter int                   CNT_WIDTH   = 16,
    parameter logic [CNT_WIDTH-1:0] SBIT_THRESH = 16'd255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  vld_in,
    input  logic [ADDR_WIDTH-1:0] addr_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  sbit_err,
    input  logic                  dbit_err,
    input  logic                  ecc_fault,
    input  logic                  clr,
    output logic                  vld_out,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  err_out,
    output logic [CNT_WIDTH-1:0]  sbit_cnt,
    output logic [CNT_WIDTH-1:0]  dbit_cnt,
    output logic [CNT_WIDTH-1:0]  fault_cnt,
    output logic                  cap_vld,
    output logic [ADDR_WIDTH-1:0] cap_addr,
    output logic [1:0]            cap_type,
    output logic                  irq
);

    logic                  vld_q, vld_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  err_q, err_d;
    logic [0:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] cap_addr_q, cap_addr_d;
    logic [1:0]            cap_type_q, cap_type_d;
    logic                  irq_q, irq_d;

    logic [2:0]            cnt_inc;
    logic [CNT_WIDTH-1:0]  cnt_val [3];
    logic [CNT_WIDTH-1:0]  sbit_base;
    logic [CNT_WIDTH-1:0]  sbit_next;
    logic                  any_err;

    assign cnt_inc = {vld_in & ecc_fault, vld_in & dbit_err, vld_in & sbit_err};
    assign any_err = vld_in & (sbit_err | dbit_err | ecc_fault);

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
            ecc_sat_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_cnt (
                .clk   (clk),
                .rst_n (rst_n),
                .clr   (clr),
                .inc   (cnt_inc[gi]),
                .cnt   (cnt_val[gi])
            );
        end
    endgenerate

    always_comb begin
        vld_d  = vld_in;
        data_d = data_in;
        err_d  = vld_in & (dbit_err | ecc_fault);

        // Mirror of the sbit counter's next value, for the threshold interrupt.
        sbit_base = clr ? '0 : cnt_val[0];
        sbit_next = sbit_base;
        if (cnt_inc[0] && (sbit_base != {CNT_WIDTH{1'b1}})) begin
            sbit_next = sbit_base + 1'b1;
        end

        state_d    = clr ? CAP_IDLE : state_q;
        cap_addr_d = clr ? '0 : cap_addr_q;
        cap_type_d = clr ? ERR_NONE : cap_type_q;
        if ((state_d == CAP_IDLE) && any_err) begin
            state_d    = CAP_HELD;
            cap_addr_d = addr_in;
            cap_type_d = err_type(sbit_err, dbit_err, ecc_fault);
        end

        irq_d = clr ? 1'b0 : irq_q;
        if (vld_in && (dbit_err || ecc_fault)) begin
            irq_d = 1'b1;
        end
        if ((SBIT_THRESH != '0) && (sbit_next == SBIT_THRESH)) begin
            irq_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q      <= 1'b0;
            data_q     <= '0;
            err_q      <= 1'b0;
            state_q    <= CAP_IDLE;
            cap_addr_q <= '0;
            cap_type_q <= ERR_NONE;
            irq_q      <= 1'b0;
        end else begin
            vld_q      <= vld_d;
            data_q     <= data_d;
            err_q      <= err_d;
            state_q    <= state_d;
            cap_addr_q <= cap_addr_d;
            cap_type_q <= cap_type_d;
            irq_q      <= irq_d;
        end
    end

    assign vld_out   = vld_q;
    assign data_out  = data_q;
    assign err_out   = err_q;
    assign sbit_cnt  = cnt_val[0];
    assign dbit_cnt  = cnt_val[1];
    assign fault_cnt = cnt_val[2];
    assign cap_vld   = (state_q == CAP_HELD);
    assign cap_addr  = cap_addr_q;
    assign cap_type  = cap_type_q;
    assign irq       = irq_q;

endmodule

// File: tb/tb_ecc_160_err_monitor.sv
// Directed bench for ecc_160_err_monitor, built with 4-bit counters and an
// sbit threshold of 5 so saturation and threshold behaviour are reachable.
module tb_ecc_160_err_monitor;

    localparam int DW = 160;
    localparam int AW = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          vld_in;
    logic [AW-1:0] addr_in;
    logic [DW-1:0] data_in;
    logic          sbit_err, dbit_err, ecc_fault, clr;
    logic          vld_out, err_out, cap_vld, irq;
    logic [DW-1:0] data_out;
    logic [CW-1:0] sbit_cnt, dbit_cnt, fault_cnt;
    logic [AW-1:0] cap_addr;
    logic [1:0]    cap_type;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ecc_160_err_monitor #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .CNT_WIDTH   (CW),
        .SBIT_THRESH (4'd5)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .vld_in    (vld_in),
        .addr_in   (addr_in),
        .data_in   (data_in),
        .sbit_err  (sbit_err),
        .dbit_err  (dbit_err),
        .ecc_fault (ecc_fault),
        .clr       (clr),
        .vld_out   (vld_out),
        .data_out  (data_out),
        .err_out   (err_out),
        .sbit_cnt  (sbit_cnt),
        .dbit_cnt  (dbit_cnt),
        .fault_cnt (fault_cnt),
        .cap_vld   (cap_vld),
        .cap_addr  (cap_addr),
        .cap_type  (cap_type),
        .irq       (irq)
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic v, input logic [AW-1:0] a, input logic s, input logic d, input logic f);
        vld_in    = v;
        addr_in   = a;
        sbit_err  = s;
        dbit_err  = d;
        ecc_fault = f;
    endtask

    task automatic chk_state(input string tag, input int s, input int d, input int f,
                             input logic cv, input logic [AW-1:0] ca, input logic [1:0] ct,
                             input logic iq);
        chk({tag, ".sbit_cnt"},  DW'(sbit_cnt),  DW'(s));
        chk({tag, ".dbit_cnt"},  DW'(dbit_cnt),  DW'(d));
        chk({tag, ".fault_cnt"}, DW'(fault_cnt), DW'(f));
        chk({tag, ".cap_vld"},   DW'(cap_vld),   DW'(cv));
        chk({tag, ".cap_addr"},  DW'(cap_addr),  DW'(ca));
        chk({tag, ".cap_type"},  DW'(cap_type),  DW'(ct));
        chk({tag, ".irq"},       DW'(irq),       DW'(iq));
    endtask

    initial begin
        logic [DW-1:0] pat_a5;
        logic [DW-1:0] pat_3c;
        pat_a5 = {20{8'hA5}};
        pat_3c = {20{8'h3C}};
        clr    = 1'b0;
        data_in = pat_a5;

        // Reset held with every input active
        rst_n = 1'b0;
        beat(1'b1, 8'hFF, 1'b1, 1'b1, 1'b1);
        clr = 1'b1;
        repeat (3) tick();
        $display("reset held 3 cycles");
        chk("rst.vld_out",  DW'(vld_out), DW'(0));
        chk("rst.data_out", data_out,     DW'(0));
        chk("rst.err_out",  DW'(err_out), DW'(0));
        chk_state("rst", 0, 0, 0, 1'b0, 8'h00, 2'b00, 1'b0);

        // Clean pass-through beat
        rst_n = 1'b1;
        clr   = 1'b0;
        beat(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        tick();
        $display("pass-through beat A5");
        chk("pass.vld_out",  DW'(vld_out), DW'(1));
        chk("pass.data_out", data_out,     pat_a5);
        chk("pass.err_out",  DW'(err_out), DW'(0));
        chk_state("pass", 0, 0, 0, 1'b0, 8'h00, 2'b00, 1'b0);

        // First-error capture: sbit then dbit
        data_in = pat_3c;
        beat(1'b1, 8'h10, 1'b1, 1'b0, 1'b0);
        tick();
        $display("sbit beat @10");
        chk("sb.err_out", DW'(err_out), DW'(0));
        chk("sb.data_out", data_out, pat_3c);
        chk_state("sb", 1, 0, 0, 1'b1, 8'h10, 2'b01, 1'b0);

        beat(1'b1, 8'h20, 1'b0, 1'b1, 1'b0);
        tick();
        $display("dbit beat @20");
        chk("db.err_out", DW'(err_out), DW'(1));
        chk_state("db", 1, 1, 0, 1'b1, 8'h10, 2'b01, 1'b1);

        beat(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        tick();
        $display("idle cycle");
        chk("idle.vld_out", DW'(vld_out), DW'(0));
        chk("idle.err_out", DW'(err_out), DW'(0));

        // Lone clr
        clr = 1'b1;
        tick();
        clr = 1'b0;
        $display("lone clr");
        chk_state("clr1", 0, 0, 0, 1'b0, 8'h00, 2'b00, 1'b0);

        // Flags without valid are ignored
        beat(1'b0, 8'h33, 1'b1, 1'b1, 1'b1);
        tick();
        $display("flags with vld_in=0");
        chk("novld.err_out", DW'(err_out), DW'(0));
        chk_state("novld", 0, 0, 0, 1'b0, 8'h00, 2'b00, 1'b0);

        // Threshold at 5, saturation at 15
        for (int i = 1; i <= 20; i++) begin
            beat(1'b1, AW'(i), 1'b1, 1'b0, 1'b0);
            tick();
            $display("sbit beat %0d: sbit_cnt=%0d irq=%0b", i, sbit_cnt, irq);
            chk("sat.sbit_cnt", DW'(sbit_cnt), DW'((i > 15) ? 15 : i));
            chk("sat.irq",      DW'(irq),      DW'(i >= 5));
        end
        chk_state("sat_end", 15, 0, 0, 1'b1, 8'h01, 2'b01, 1'b1);

        beat(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        tick();
        $display("sbit with vld_in=0 at saturation");
        chk("sat_novld.sbit_cnt", DW'(sbit_cnt), DW'(15));

        // clr colliding with a fault beat
        clr = 1'b1;
        tick();
        clr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            beat(1'b1, AW'(8'h50 + i), 1'b0, 1'b1, 1'b0);
            tick();
        end
        $display("three dbit beats");
        chk_state("pre_col", 0, 3, 0, 1'b1, 8'h50, 2'b10, 1'b1);

        data_in = pat_a5;
        clr = 1'b1;
        beat(1'b1, 8'h44, 1'b0, 1'b0, 1'b1);
        tick();
        clr = 1'b0;
        $display("clr + fault beat @44");
        chk("col.data_out", data_out, pat_a5);
        chk("col.err_out",  DW'(err_out), DW'(1));
        chk_state("col", 0, 0, 1, 1'b1, 8'h44, 2'b11, 1'b1);

        beat(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        $display("lone clr after collision");
        chk_state("clr2", 0, 0, 0, 1'b0, 8'h00, 2'b00, 1'b0);

        // Multi-flag beat from IDLE
        beat(1'b1, 8'h7F, 1'b0, 1'b1, 1'b1);
        tick();
        $display("dbit+fault beat @7F");
        chk("multi.err_out", DW'(err_out), DW'(1));
        chk_state("multi", 0, 1, 1, 1'b1, 8'h7F, 2'b11, 1'b1);

        // Reset overrides clr mid-operation; next beat handled normally
        rst_n = 1'b0;
        clr   = 1'b1;
        beat(1'b1, 8'h66, 1'b1, 1'b0, 1'b0);
        tick();
        $display("reset with clr mid-operation");
        chk("mrst.vld_out", DW'(vld_out), DW'(0));
        chk_state("mrst", 0, 0, 0, 1'b0, 8'h00, 2'b00, 1'b0);

        rst_n = 1'b1;
        clr   = 1'b0;
        beat(1'b1, 8'h03, 1'b1, 1'b0, 1'b0);
        tick();
        $display("first beat after reset: sbit @03");
        chk("post.vld_out", DW'(vld_out), DW'(1));
        chk_state("post", 1, 0, 0, 1'b1, 8'h03, 2'b01, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
